// File: rtl/writeback_hazard_unit_pkg.sv
// Purpose: shared constants for the write-back / hazard slice (slot indices, entry layout).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package writeback_hazard_unit_pkg;

    // Architectural zero register: never written, never tracked, never matched.
    localparam int REG_ZERO = 0;

    // Scoreboard slot indices, oldest entry at the highest index.
    localparam int SLOT_EXE = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;
    localparam int SB_SLOTS = 3;

    // Entry layout, MSB to LSB: {valid, dest, is_load}.
    localparam int SB_VALID_W = 1;
    localparam int SB_LOAD_W  = 1;

    // Total entry width for a given register address width.
    function automatic int sb_entry_w(input int reg_aw);
        return SB_VALID_W + reg_aw + SB_LOAD_W;
    endfunction

endpackage

// File: rtl/writeback_hazard_unit_if.sv
// Purpose: bundles the decode-side, MEM-side and register-file write-port signals.
// Latency: n/a (wiring only).
// Backpressure: hazard_stall is the only backpressure; it freezes decode.
interface writeback_hazard_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // Decode stage
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic              id_mem_w_en;
    logic              id_is_imm;
    // MEM stage
    logic              mem_valid;
    logic              mem_wb_en;
    logic              mem_r_en;
    logic [REG_AW-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    // Outputs
    logic              hazard_stall;
    logic              write;
    logic [REG_AW-1:0] lastDestination;
    logic [DATA_W-1:0] writedata;

    // Pipeline side that drives decode/MEM information and consumes the results.
    modport master (
        output id_valid, id_src1, id_src2, id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, id_is_imm,
        output mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_result, mem_read_data,
        input  hazard_stall, write, lastDestination, writedata
    );

    // The write-back / hazard unit itself.
    modport slave (
        input  id_valid, id_src1, id_src2, id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, id_is_imm,
        input  mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_result, mem_read_data,
        output hazard_stall, write, lastDestination, writedata
    );
endinterface

// File: rtl/writeback_hazard_unit_hazard_scoreboard.sv
// Purpose: 3-slot EXE/MEM/WB shift chain of pending register writes plus RAW stall detection.
// Latency: stall is combinational from slots and decode inputs; slots advance every clock.
// Backpressure: raises o_hazard_stall; the chain keeps shifting, a stalled cycle injects a bubble.
module hazard_scoreboard
    import writeback_hazard_unit_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FORWARD_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_src1,
    input  logic [REG_AW-1:0] i_id_src2,
    input  logic [REG_AW-1:0] i_id_dest,
    input  logic              i_id_wb_en,
    input  logic              i_id_mem_r_en,
    input  logic              i_id_mem_w_en,
    input  logic              i_id_is_imm,
    output logic              o_hazard_stall
);

    localparam int ENTRY_W = sb_entry_w(REG_AW);
    localparam int VLD_BIT = ENTRY_W - 1;

    logic [ENTRY_W-1:0] r_slot [SB_SLOTS];

    logic              w_use1;
    logic              w_use2;
    logic              w_stall;
    logic              w_issue;
    logic [ENTRY_W-1:0] w_new_entry;

    // A store reads src2 as its data even when the operand mux selects an immediate.
    assign w_use1 = i_id_valid & (i_id_src1 != REG_AW'(REG_ZERO));
    assign w_use2 = i_id_valid & (i_id_src2 != REG_AW'(REG_ZERO)) & (~i_id_is_imm | i_id_mem_w_en);

    // Compare each used source against every pending destination.
    always_comb begin
        w_stall = 1'b0;
        for (int s = 0; s < SB_SLOTS; s++) begin
            logic              v;
            logic [REG_AW-1:0] d;
            logic              ld;
            logic              hit;
            v   = r_slot[s][VLD_BIT];
            d   = r_slot[s][REG_AW:1];
            ld  = r_slot[s][0];
            hit = v & ((w_use1 & (d == i_id_src1)) | (w_use2 & (d == i_id_src2)));
            if (FORWARD_EN == 0) begin
                w_stall = w_stall | hit;
            end else if (s == SLOT_EXE) begin
                // With forwarding only a load still in EXE has no data available yet.
                w_stall = w_stall | (hit & ld);
            end
        end
    end

    assign o_hazard_stall = w_stall;

    // Only real, non-stalled, register-writing instructions with a non-zero target are tracked.
    assign w_issue     = i_id_valid & ~w_stall & i_id_wb_en & (i_id_dest != REG_AW'(REG_ZERO));
    assign w_new_entry = w_issue ? {1'b1, i_id_dest, i_id_mem_r_en} : '0;

    // Shift the chain EXE->MEM->WB every clock; stall only affects what enters EXE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SB_SLOTS; s++) begin
                r_slot[s] <= '0;
            end
        end else begin
            r_slot[SLOT_EXE] <= w_new_entry;
            r_slot[SLOT_MEM] <= r_slot[SLOT_EXE];
            r_slot[SLOT_WB]  <= r_slot[SLOT_MEM];
        end
    end

endmodule

// File: rtl/writeback_hazard_unit.sv
// Purpose: MEM/WB register driving the register-file write port, plus decode RAW hazard stall.
// Latency: 1 cycle mem_* -> write/lastDestination/writedata; hazard_stall combinational.
// Backpressure: hazard_stall freezes decode; write-back and the scoreboard never stall.
module writeback_hazard_unit
    import writeback_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FORWARD_EN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    writeback_hazard_unit_if.slave bus
);

    logic              r_write;
    logic [REG_AW-1:0] r_last_dest;
    logic [DATA_W-1:0] r_wdata;

    logic              w_write_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_stall;

    // Register zero is silently dropped at the write port.
    assign w_write_nxt = bus.mem_valid & bus.mem_wb_en & (bus.mem_dest != REG_AW'(REG_ZERO));
    assign w_wdata_nxt = bus.mem_r_en ? bus.mem_read_data : bus.mem_alu_result;

    // MEM/WB boundary register feeding the register-file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_last_dest <= '0;
            r_wdata     <= '0;
        end else begin
            r_write     <= w_write_nxt;
            r_last_dest <= bus.mem_dest;
            r_wdata     <= w_wdata_nxt;
        end
    end

    hazard_scoreboard #(
        .REG_AW     (REG_AW),
        .FORWARD_EN (FORWARD_EN)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .i_id_valid     (bus.id_valid),
        .i_id_src1      (bus.id_src1),
        .i_id_src2      (bus.id_src2),
        .i_id_dest      (bus.id_dest),
        .i_id_wb_en     (bus.id_wb_en),
        .i_id_mem_r_en  (bus.id_mem_r_en),
        .i_id_mem_w_en  (bus.id_mem_w_en),
        .i_id_is_imm    (bus.id_is_imm),
        .o_hazard_stall (w_stall)
    );

    assign bus.hazard_stall    = w_stall;
    assign bus.write           = r_write;
    assign bus.lastDestination = r_last_dest;
    assign bus.writedata       = r_wdata;

endmodule
